// File: rtl/eccdh3des_pkg.sv
// Shared definitions for the DES stream sequencer: FSM encoding and default
// parameter values.
package eccdh3des_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

    localparam int unsigned DEF_ADDRSIZE     = 14;
    localparam int unsigned DEF_BLKW         = 64;
    localparam int unsigned DEF_RD_LAT       = 2;
    localparam int unsigned DEF_MAX_INFLIGHT = 4;

endpackage

// File: rtl/sram_rd_pipe.sv
// Tracks outstanding source SRAM reads through the read latency and registers
// the returned word as a single-cycle block for the cipher core.
module sram_rd_pipe #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned BLKW   = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            rden,
    input  logic [BLKW-1:0] q,
    output logic            valid,
    output logic [BLKW-1:0] data
);

    logic [RD_LAT-1:0] vld_sr;

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            vld_sr <= '0;
            valid  <= 1'b0;
        end else begin
            vld_sr[0] <= rden;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
            valid <= vld_sr[RD_LAT-1];
        end
    end

    // Data is only captured when a tracked read lands, so the bus holds otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data <= '0;
        end else if (vld_sr[RD_LAT-1] && !flush) begin
            data <= q;
        end
    end

endmodule

// File: rtl/des_stream_sequencer.sv
// Streams blocks from a source SRAM through a pipelined cipher core into a
// destination SRAM, bounding the number of blocks in flight.
module des_stream_sequencer
    import eccdh3des_pkg::*;
#(
    parameter int unsigned ADDRSIZE     = DEF_ADDRSIZE,
    parameter int unsigned BLKW         = DEF_BLKW,
    parameter int unsigned RD_LAT       = DEF_RD_LAT,
    parameter int unsigned MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDRSIZE-1:0] src_base,
    input  logic [ADDRSIZE-1:0] dst_base,
    input  logic [ADDRSIZE-1:0] num_blocks,
    output logic                src_rden,
    output logic [ADDRSIZE-1:0] src_addr,
    input  logic [BLKW-1:0]     src_q,
    output logic [BLKW-1:0]     core_data_in,
    output logic                core_valid_in,
    input  logic                core_valid_out,
    input  logic [BLKW-1:0]     core_data_out,
    output logic                dst_wren,
    output logic [ADDRSIZE-1:0] dst_addr,
    output logic [BLKW-1:0]     dst_data,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [ADDRSIZE-1:0] blocks_written
);

    localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [ADDRSIZE-1:0] ONE = ADDRSIZE'(1);

    seq_state_t          state, state_next;
    logic [ADDRSIZE-1:0] src_base_r, dst_base_r, num_r, issued;
    logic [IW-1:0]       inflight;
    logic                issue, ret, cancel;

    assign cancel   = abort && (state != IDLE);
    assign issue    = (state == FETCH) && (issued < num_r) && (inflight < IW'(MAX_INFLIGHT));
    // Results arriving outside an active job, or alongside an abort, are dropped.
    assign ret      = core_valid_out && !abort && ((state == FETCH) || (state == DRAIN));
    assign src_rden = issue;
    assign src_addr = src_base_r + issued;
    assign busy     = (state != IDLE);
    assign done     = (state == FINISH) && !abort;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = (num_blocks == '0) ? FINISH : FETCH;
            FETCH:  if (issued == num_r) state_next = DRAIN;
            DRAIN:  if (ret && (blocks_written + ONE == num_r)) state_next = FINISH;
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (cancel) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_base_r     <= '0;
            dst_base_r     <= '0;
            num_r          <= '0;
            issued         <= '0;
            inflight       <= '0;
            blocks_written <= '0;
            dst_wren       <= 1'b0;
            dst_addr       <= '0;
            dst_data       <= '0;
            aborted        <= 1'b0;
        end else begin
            dst_wren <= ret;
            aborted  <= cancel;
            if (ret) begin
                dst_data       <= core_data_out;
                dst_addr       <= dst_base_r + blocks_written;
                blocks_written <= blocks_written + ONE;
            end
            if ((state == IDLE) && start) begin
                src_base_r     <= src_base;
                dst_base_r     <= dst_base;
                num_r          <= num_blocks;
                issued         <= '0;
                inflight       <= '0;
                blocks_written <= '0;
            end else if (cancel) begin
                inflight <= '0;
            end else begin
                if (issue) issued <= issued + ONE;
                if (issue && !ret)      inflight <= inflight + IW'(1);
                else if (!issue && ret) inflight <= inflight - IW'(1);
            end
        end
    end

    sram_rd_pipe #(
        .RD_LAT (RD_LAT),
        .BLKW   (BLKW)
    ) u_rd_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (cancel),
        .rden    (issue),
        .q       (src_q),
        .valid   (core_valid_in),
        .data    (core_data_in)
    );

endmodule

// File: tb/tb_des_stream_sequencer.sv
// Scoreboard bench for des_stream_sequencer: models the source SRAM and a
// fixed-latency cipher core, and checks every read and write in order.
module tb_des_stream_sequencer;

    localparam int unsigned AW      = 14;
    localparam int unsigned BW      = 64;
    localparam int unsigned CORE_LAT = 5;
    localparam logic [63:0] KEY     = 64'h0123_4567_89AB_CDEF;

    logic          clk = 1'b0;
    logic          reset_n, start, abort;
    logic [AW-1:0] src_base, dst_base, num_blocks;
    logic          src_rden;
    logic [AW-1:0] src_addr;
    logic [BW-1:0] src_q;
    logic [BW-1:0] core_data_in;
    logic          core_valid_in;
    logic          core_valid_out;
    logic [BW-1:0] core_data_out;
    logic          dst_wren;
    logic [AW-1:0] dst_addr;
    logic [BW-1:0] dst_data;
    logic          busy, done, aborted;
    logic [AW-1:0] blocks_written;

    always #5 clk = ~clk;

    des_stream_sequencer #(
        .ADDRSIZE     (AW),
        .BLKW         (BW),
        .RD_LAT       (2),
        .MAX_INFLIGHT (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .src_base       (src_base),
        .dst_base       (dst_base),
        .num_blocks     (num_blocks),
        .src_rden       (src_rden),
        .src_addr       (src_addr),
        .src_q          (src_q),
        .core_data_in   (core_data_in),
        .core_valid_in  (core_valid_in),
        .core_valid_out (core_valid_out),
        .core_data_out  (core_data_out),
        .dst_wren       (dst_wren),
        .dst_addr       (dst_addr),
        .dst_data       (dst_data),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .blocks_written (blocks_written)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_fn(input logic [AW-1:0] a);
        return {16'hC0DE, 2'b00, a, 32'(a) * 32'h9E37_79B9};
    endfunction

    // Source SRAM: two-cycle read latency, address registered twice.
    logic [AW-1:0] ad1 = '0, ad2 = '0;
    always @(posedge clk) begin
        ad1 <= src_addr;
        ad2 <= ad1;
    end
    assign src_q = mem_fn(ad2);

    // Cipher core model: fixed latency, result = block ^ KEY, stallable.
    typedef struct {
        int unsigned rdy;
        logic [63:0] d;
    } core_ent_t;
    core_ent_t   core_q[$];
    int unsigned cyc = 0;
    logic        stall = 1'b0;

    initial begin
        core_ent_t e;
        core_valid_out = 1'b0;
        core_data_out  = '0;
        forever begin
            @(negedge clk);
            if (core_valid_in === 1'b1) core_q.push_back('{cyc + CORE_LAT, core_data_in});
            @(posedge clk);
            #1;
            cyc++;
            if (!stall && core_q.size() > 0 && core_q[0].rdy <= cyc) begin
                e = core_q.pop_front();
                core_valid_out = 1'b1;
                core_data_out  = e.d ^ KEY;
            end else begin
                core_valid_out = 1'b0;
                core_data_out  = '0;
            end
        end
    end

    // Scoreboard queues and event counters.
    logic [AW-1:0] exp_rd[$];
    logic [AW-1:0] exp_wa[$];
    logic [63:0]   exp_wd[$];
    int unsigned rd_cnt = 0, wr_cnt = 0, done_cnt = 0, abt_cnt = 0, cin_cnt = 0;

    always @(negedge clk) begin
        if (src_rden === 1'b1) begin
            rd_cnt++;
            if (exp_rd.size() == 0) check("rd_unexpected", 64'(src_addr), 64'h0);
            else check("rd_addr", 64'(src_addr), 64'(exp_rd.pop_front()));
        end
        if (dst_wren === 1'b1) begin
            wr_cnt++;
            if (exp_wa.size() == 0) begin
                check("wr_unexpected", 64'(dst_addr), 64'h0);
            end else begin
                check("wr_addr", 64'(dst_addr), 64'(exp_wa.pop_front()));
                check("wr_data", dst_data, exp_wd.pop_front());
            end
        end
        if (core_valid_in === 1'b1) cin_cnt++;
        if (done === 1'b1) done_cnt++;
        if (aborted === 1'b1) abt_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [AW-1:0] sb, input logic [AW-1:0] db,
                           input logic [AW-1:0] n, input bit push_wr);
        logic [AW-1:0] a;
        for (int i = 0; i < int'(n); i++) begin
            a = sb + AW'(i);
            exp_rd.push_back(a);
            if (push_wr) begin
                exp_wa.push_back(db + AW'(i));
                exp_wd.push_back(mem_fn(a) ^ KEY);
            end
        end
        src_base   = sb;
        dst_base   = db;
        num_blocks = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned max_cyc);
        for (int unsigned i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (busy === 1'b0) return;
        end
        check("idle_timeout", 64'h1, 64'h0);
    endtask

    task automatic check_queues_empty(input string tag);
        check({tag, "_rdq"}, 64'(exp_rd.size()), 64'h0);
        check({tag, "_wrq"}, 64'(exp_wa.size()), 64'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({src_rden, core_valid_in, dst_wren, busy, done, aborted}), 64'h0);
        check({tag, "_addr"}, 64'({src_addr, dst_addr, blocks_written}), 64'h0);
        check({tag, "_cdata"}, core_data_in, 64'h0);
        check({tag, "_ddata"}, dst_data, 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned d0, a0, r0, w0, c0;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        src_base = '0; dst_base = '0; num_blocks = '0;
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        reset_n = 1'b1;
        tick();

        // Scenario 1: three blocks, core latency 5.
        d0 = done_cnt;
        run_job(14'd1, 14'd1, 14'd3, 1'b1);
        wait_idle(200);
        check("s1_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("s1_blocks_written", 64'(blocks_written), 64'd3);
        check_queues_empty("s1");
        tick();

        // Scenario 2: eight blocks with the core stalled.
        stall = 1'b1;
        r0 = rd_cnt;
        run_job(14'd40, 14'd500, 14'd8, 1'b1);
        repeat (20) tick();
        check("s2_reads_while_stalled", 64'(rd_cnt - r0), 64'd4);
        check("s2_busy_stalled", 64'(busy), 64'd1);
        stall = 1'b0;
        wait_idle(400);
        check("s2_reads_total", 64'(rd_cnt - r0), 64'd8);
        check("s2_blocks_written", 64'(blocks_written), 64'd8);
        check_queues_empty("s2");
        tick();

        // Scenario 3: source and destination address wrap.
        run_job(14'd16383, 14'd16383, 14'd2, 1'b1);
        wait_idle(200);
        check("s3_blocks_written", 64'(blocks_written), 64'd2);
        check_queues_empty("s3");
        tick();

        // Scenario 4: empty job.
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        run_job(14'd7, 14'd9, 14'd0, 1'b1);
        @(negedge clk);
        check("s4_done", 64'(done), 64'd1);
        check("s4_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("s4_done_after", 64'(done), 64'd0);
        check("s4_busy_after", 64'(busy), 64'd0);
        check("s4_no_rw", 64'((rd_cnt - r0) + (wr_cnt - w0)), 64'd0);
        check("s4_done_pulses", 64'(done_cnt - d0), 64'd1);
        tick();

        // Scenario 5: abort in DRAIN with two blocks in flight.
        stall = 1'b1;
        d0 = done_cnt; a0 = abt_cnt; w0 = wr_cnt; c0 = cin_cnt;
        run_job(14'd10, 14'd20, 14'd2, 1'b0);
        for (int i = 0; i < 50 && cin_cnt < c0 + 2; i++) @(negedge clk);
        check("s5_core_inputs", 64'(cin_cnt - c0), 64'd2);
        tick();
        abort = 1'b1;
        @(negedge clk);
        check("s5_busy_at_abort", 64'(busy), 64'd1);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("s5_aborted", 64'(aborted), 64'd1);
        check("s5_busy_after", 64'(busy), 64'd0);
        stall = 1'b0;
        repeat (20) tick();
        check("s5_no_writes", 64'(wr_cnt - w0), 64'd0);
        check("s5_abort_pulses", 64'(abt_cnt - a0), 64'd1);
        check("s5_no_done", 64'(done_cnt - d0), 64'd0);
        check_queues_empty("s5");

        // Scenario 6a: start while busy is ignored.
        d0 = done_cnt;
        run_job(14'd1, 14'd1, 14'd3, 1'b1);
        tick();
        src_base = 14'd100; dst_base = 14'd200; num_blocks = 14'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(200);
        check("s6_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("s6_blocks_written", 64'(blocks_written), 64'd3);
        check_queues_empty("s6a");
        tick();

        // Scenario 6b: reset in the middle of FETCH.
        stall = 1'b1;
        d0 = done_cnt; a0 = abt_cnt;
        run_job(14'd200, 14'd300, 14'd6, 1'b0);
        tick();
        reset_n = 1'b0;
        tick();
        @(negedge clk);
        check_all_zero("s6_reset");
        exp_rd.delete();
        tick();
        reset_n = 1'b1;
        stall = 1'b0;
        repeat (20) tick();
        check("s6_no_done", 64'(done_cnt - d0), 64'd0);
        check("s6_no_abort", 64'(abt_cnt - a0), 64'd0);
        check("s6_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
